// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared state type and widths for shift_out_sequencer.
// Imported by rr_arbiter and shift_out_sequencer.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT,
        LATCH
    } seq_state_t;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 3;

    function automatic int div_cnt_w(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant among requesters, round-robin by default.
// Define SHIFT_SEQ_FIXED_PRIO_EN for fixed priority (lowest index wins).
module rr_arbiter
    import shift_seq_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

`ifdef SHIFT_SEQ_FIXED_PRIO_EN

    always_comb begin
        logic hit;
        hit   = 1'b0;
        grant = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            grant[j] = req[j] && !hit;
            hit      = hit || req[j];
        end
    end

`else

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PW-1:0] last;

    // Prefer the first requester above last; otherwise wrap to the lowest.
    always_comb begin
        logic               hit_hi;
        logic               hit_all;
        logic [NUM_REQ-1:0] upper;
        logic [NUM_REQ-1:0] pick_hi;
        logic [NUM_REQ-1:0] pick_all;
        hit_hi   = 1'b0;
        hit_all  = 1'b0;
        upper    = '0;
        pick_hi  = '0;
        pick_all = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            upper[j]    = req[j] && (j > int'(last));
            pick_hi[j]  = upper[j] && !hit_hi;
            hit_hi      = hit_hi || upper[j];
            pick_all[j] = req[j] && !hit_all;
            hit_all     = hit_all || req[j];
        end
        grant = hit_hi ? pick_hi : pick_all;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= '0;
        end else if (advance) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (grant[j]) last <= PW'(j);
            end
        end
    end

`endif

endmodule

// File: rtl/shift_out_sequencer.sv
// shift_out_sequencer: arbitrates byte producers onto one MSB-first shift register.
// Define SHIFT_SEQ_FIXED_PRIO_EN to replace round-robin with fixed priority.
module shift_out_sequencer
    import shift_seq_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DIV     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [BYTE_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [BYTE_W-1:0]         sr_data_in,
    output logic                      sr_load,
    output logic                      sr_shift,
    input  logic                      sr_bit,
    output logic                      ser_data,
    output logic                      ser_clk,
    output logic                      ser_latch,
    output logic                      busy
);

    localparam int DCW = div_cnt_w(DIV);

    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);
    localparam logic [DCW-1:0] DIV_HALF = DCW'(DIV / 2);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = '1;

    seq_state_t           state;
    logic [DCW-1:0]       div_cnt;
    logic [DCW-1:0]       div_nxt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BIT_CNT_W-1:0] bit_nxt;
    logic [NUM_REQ-1:0]   grant;
    logic [BYTE_W-1:0]    win_data;
    logic                 xfer;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (xfer),
        .grant   (grant)
    );

    // Gated by rst_n so nothing is offered while reset is held.
    assign req_ready = (state == IDLE && rst_n) ? grant : '0;
    assign xfer      = |(req_valid & req_ready);
    assign ser_data  = sr_bit;
    assign busy      = (state != IDLE);

    always_comb begin
        win_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (req_ready[j]) win_data = req_data[BYTE_W*j +: BYTE_W];
        end
    end

    always_comb begin
        div_nxt = div_cnt + 1'b1;
        bit_nxt = bit_cnt;
        if (div_cnt == DIV_LAST) begin
            div_nxt = '0;
            bit_nxt = bit_cnt + 1'b1;
        end
    end

    // Strobes are registered from the counts of the cycle being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            sr_data_in <= '0;
            sr_load    <= 1'b0;
            sr_shift   <= 1'b0;
            ser_clk    <= 1'b0;
            ser_latch  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (xfer) begin
                        sr_data_in <= win_data;
                        sr_load    <= 1'b1;
                        state      <= LOAD;
                    end
                end
                LOAD: begin
                    sr_load  <= 1'b0;
                    sr_shift <= 1'b0;
                    ser_clk  <= 1'b0;
                    div_cnt  <= '0;
                    bit_cnt  <= '0;
                    state    <= SHIFT;
                end
                SHIFT: begin
                    div_cnt <= div_nxt;
                    bit_cnt <= bit_nxt;
                    if (div_cnt == DIV_LAST && bit_cnt == BIT_LAST) begin
                        ser_clk   <= 1'b0;
                        sr_shift  <= 1'b0;
                        ser_latch <= 1'b1;
                        state     <= LATCH;
                    end else begin
                        ser_clk  <= (div_nxt >= DIV_HALF);
                        sr_shift <= (div_nxt == DIV_LAST)
                                    && (bit_nxt != BIT_LAST);
                    end
                end
                LATCH: begin
                    ser_latch <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_out_sequencer.sv
// Bench for shift_out_sequencer: queued transaction model vs serial monitor.
// Build with +define+SHIFT_SEQ_FIXED_PRIO_EN to check the fixed-priority variant.
`timescale 1ns/1ps
module tb_shift_out_sequencer;

    localparam int N        = 2;
    localparam int D        = 4;
    localparam int BYTE_CYC = 8*D + 3;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data  = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     sr_data_in;
    logic           sr_load, sr_shift, sr_bit;
    logic           ser_data, ser_clk, ser_latch, busy;
    logic [7:0]     sr_q = '0;

    logic [0:0] b_valid = '0;
    logic [7:0] b_data  = '0;
    logic [0:0] b_ready;
    logic [7:0] b_sr_in;
    logic       b_load, b_shift, b_bit;
    logic       b_ser, b_clk, b_latch, b_busy;
    logic [7:0] b_sr = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        int         who;
        logic [7:0] data;
        int         acc;
    } exp_t;

    exp_t sb[$];
    int   m_ptr  = 0;
    int   m_free = 0;

    shift_out_sequencer #(.NUM_REQ(N), .DIV(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .sr_data_in (sr_data_in),
        .sr_load    (sr_load),
        .sr_shift   (sr_shift),
        .sr_bit     (sr_bit),
        .ser_data   (ser_data),
        .ser_clk    (ser_clk),
        .ser_latch  (ser_latch),
        .busy       (busy)
    );

    shift_out_sequencer #(.NUM_REQ(1), .DIV(2)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (b_valid),
        .req_data   (b_data),
        .req_ready  (b_ready),
        .sr_data_in (b_sr_in),
        .sr_load    (b_load),
        .sr_shift   (b_shift),
        .sr_bit     (b_bit),
        .ser_data   (b_ser),
        .ser_clk    (b_clk),
        .ser_latch  (b_latch),
        .busy       (b_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External 8-bit parallel-load / MSB-first shift registers.
    always @(posedge clk) begin
        if (sr_load) sr_q <= sr_data_in;
        else if (sr_shift) sr_q <= {sr_q[6:0], 1'b0};
        if (b_load) b_sr <= b_sr_in;
        else if (b_shift) b_sr <= {b_sr[6:0], 1'b0};
    end
    assign sr_bit = sr_q[7];
    assign b_bit  = b_sr[7];

    function automatic void check(input string name,
                                  input logic [31:0] act,
                                  input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endfunction

    function automatic int pick(input logic [N-1:0] v);
`ifdef SHIFT_SEQ_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int k = 1; k <= N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
`endif
        return -1;
    endfunction

    // Reference: one byte per 8*D+3 cycles, winner chosen by the arbitration rule.
    always @(negedge clk) begin : model
        logic [N-1:0] exp_rdy;
        exp_rdy = '0;
        if (!rst_n) begin
            m_ptr  = 0;
            m_free = 0;
            sb.delete();
        end else begin
            if (cyc >= m_free && req_valid != '0) begin
                int w;
                w = pick(req_valid);
                exp_rdy[w] = 1'b1;
                sb.push_back('{who: w, data: req_data[8*w +: 8], acc: cyc});
                m_ptr  = w;
                m_free = cyc + BYTE_CYC;
            end
            check("req_ready", 32'(req_ready), 32'(exp_rdy));
        end
    end

    int         mon_who, mon_acc, mon_load;
    int         mon_shifts, mon_rises, mon_rerr;
    logic [7:0] mon_bits;
    logic       mon_act  = 1'b0;
    logic       mon_pclk = 1'b0;
    logic       mon_both = 1'b0;
    logic       mon_idle = 1'b0;

    always @(negedge clk) begin : monitor
        if (!rst_n) begin
            mon_act  = 1'b0;
            mon_pclk = 1'b0;
            mon_idle = 1'b0;
        end else begin
            if (mon_idle) begin
                check("busy_after_latch", 32'(busy), 32'd0);
                mon_idle = 1'b0;
            end
            if ((req_valid & req_ready) != '0) begin
                mon_act    = 1'b1;
                mon_acc    = cyc;
                mon_load   = -1;
                mon_shifts = 0;
                mon_rises  = 0;
                mon_rerr   = 0;
                mon_bits   = '0;
                mon_both   = 1'b0;
                for (int i = 0; i < N; i++) begin
                    if (req_valid[i] && req_ready[i]) mon_who = i;
                end
            end else if (mon_act) begin
                if (sr_load) mon_load = cyc;
                if (sr_shift) mon_shifts++;
                if (sr_load && sr_shift) mon_both = 1'b1;
                if (ser_clk && !mon_pclk) begin
                    if (cyc != mon_acc + 2 + mon_rises*D + D/2) mon_rerr++;
                    mon_bits = {mon_bits[6:0], ser_data};
                    mon_rises++;
                end
            end
            if (ser_latch) begin
                if (!mon_act || sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL spurious_latch: ser_latch=1 want 0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("grant_who", 32'(mon_who), 32'(e.who));
                    check("accept_cycle", 32'(mon_acc), 32'(e.acc));
                    check("serial_byte", 32'(mon_bits), 32'(e.data));
                    check("load_cycle", 32'(mon_load), 32'(e.acc + 1));
                    check("latch_cycle", 32'(cyc), 32'(e.acc + 2 + 8*D));
                    check("shift_count", 32'(mon_shifts), 32'd7);
                    check("ser_clk_rises", 32'(mon_rises), 32'd8);
                    check("ser_clk_phase_err", 32'(mon_rerr), 32'd0);
                    check("load_shift_overlap", 32'(mon_both), 32'd0);
                    mon_act  = 1'b0;
                    mon_idle = 1'b1;
                end
            end
            mon_pclk = ser_clk;
        end
    end

    // Each requester presents n bytes, holding valid until accepted.
    task automatic run_traffic(input int n0, input int n1,
                               input int maxgap, input bit rnd,
                               input logic [7:0] d0, input logic [7:0] d1,
                               input int budget);
        int         rem[N];
        int         gap[N];
        logic [N-1:0] acc;
        int         t;
        rem[0] = n0;
        rem[1] = n1;
        gap[0] = 0;
        gap[1] = 0;
        t = 0;
        while ((rem[0] + rem[1] != 0 || sb.size() != 0 || busy)
               && t < budget) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            t++;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    rem[i]--;
                    req_valid[i] = 1'b0;
                    gap[i] = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
                end
                if (!req_valid[i] && rem[i] > 0) begin
                    if (gap[i] > 0) begin
                        gap[i]--;
                    end else begin
                        req_valid[i] = 1'b1;
                        req_data[8*i +: 8] = rnd ? 8'($urandom)
                                                 : ((i == 0) ? d0 : d1);
                    end
                end
            end
        end
        if (t >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL traffic_timeout: %0d cycles, want < %0d", t, budget);
        end
    endtask

    task automatic reset_mid_byte();
        int t;
        int ta;
        req_data[7:0] = 8'h5A;
        req_valid[0]  = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!req_ready[0] && t < 50);
        check("rst_test_accept", 32'(req_ready[0]), 32'd1);
        ta = cyc;
        @(posedge clk);
        #1;
        req_valid[0]   = 1'b0;
        req_data[15:8] = 8'h3C;
        req_valid[1]   = 1'b1;
        while (cyc < ta + 2 + 3*D + D/2) begin
            @(posedge clk);
            #1;
        end
        #2;
        check("pre_reset_ser_clk", 32'(ser_clk), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_sr_data_in", 32'(sr_data_in), 32'd0);
        check("rst_sr_load", 32'(sr_load), 32'd0);
        check("rst_sr_shift", 32'(sr_shift), 32'd0);
        check("rst_ser_clk", 32'(ser_clk), 32'd0);
        check("rst_ser_latch", 32'(ser_latch), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_traffic(0, 1, 0, 1'b0, 8'h00, 8'h3C, 200);
    endtask

    task automatic div2_test();
        int t;
        int shifts;
        b_data  = 8'h80;
        b_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!b_ready[0] && t < 50);
        check("div2_accept", 32'(b_ready), 32'd1);
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        shifts = 0;
        for (int k = 1; k <= 19; k++) begin
            @(negedge clk);
            if (b_shift) shifts++;
            check("div2_load", 32'(b_load), 32'(k == 1));
            check("div2_latch", 32'(b_latch), 32'(k == 18));
            if (k >= 2 && k <= 17) begin
                check("div2_ser_data", 32'(b_ser), 32'(k <= 3));
                check("div2_ser_clk", 32'((k - 2) % 2), 32'(b_clk));
            end
            if (k == 19) check("div2_busy_end", 32'(b_busy), 32'd0);
        end
        check("div2_shifts", 32'(shifts), 32'd7);
    endtask

    initial begin
        req_valid = '1;
        b_valid   = '1;
        #1;
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_sr_data_in", 32'(sr_data_in), 32'd0);
        check("reset_sr_load", 32'(sr_load), 32'd0);
        check("reset_sr_shift", 32'(sr_shift), 32'd0);
        check("reset_ser_clk", 32'(ser_clk), 32'd0);
        check("reset_ser_latch", 32'(ser_latch), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        req_valid = '0;
        b_valid   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_traffic(1, 0, 0, 1'b0, 8'hA5, 8'h00, 200);
        run_traffic(2, 2, 0, 1'b0, 8'h0F, 8'hF0, 400);
        run_traffic(3, 0, 0, 1'b0, 8'hC3, 8'h00, 400);
        run_traffic(12, 12, 40, 1'b1, 8'h00, 8'h00, 5000);
        run_traffic(2, 3, 50, 1'b1, 8'h00, 8'h00, 2000);
        reset_mid_byte();
        div2_test();

        repeat (4) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
